adder_tree_stream: RTL

ADDER_TREE_STREAM -- requirements
Module: adder_tree_stream

---
 rtl/adder_tree_pkg.sv | 26 ++
 rtl/adder_tree_stage.sv | 57 +++++
 rtl/adder_tree_stream.sv | 108 ++++++++++
 3 files changed

// File: rtl/adder_tree_pkg.sv
// Shared sizing and level-to-stage helpers for the streaming adder tree.
package adder_tree_pkg;

  function automatic int sum_width(input int data_w, input int length);
    return data_w + $clog2(length);
  endfunction

  // A single addend still passes through one (trivial) level.
  function automatic int tree_levels(input int length);
    return (length > 1) ? $clog2(length) : 1;
  endfunction

  // Tree level after which pipeline stage k registers: ceil(k*levels/stages).
  function automatic int stage_level(input int k, input int levels, input int stages);
    return (k * levels + stages - 1) / stages;
  endfunction

  // Number of partial sums alive after `level` pairwise reductions.
  function automatic int level_count(input int length, input int level);
    int n;
    n = length;
    for (int l = 0; l < level; l++) n = (n + 1) / 2;
    return n;
  endfunction

endpackage

// File: rtl/adder_tree_stage.sv
// One pipeline register of the adder tree: valid bit, partial sums and tag,
// loading whenever it is empty or its downstream neighbour loads.
module adder_tree_stage #(
  parameter int N  = 1,
  parameter int W  = 8,
  parameter int TW = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                valid_i,
  input  logic [N-1:0][W-1:0] data_i,
  input  logic [TW-1:0]       tag_i,
  input  logic                down_load_i,
  output logic                load_o,
  output logic                valid_o,
  output logic [N-1:0][W-1:0] data_o,
  output logic [TW-1:0]       tag_o
);

  logic                valid_q, valid_d;
  logic [N-1:0][W-1:0] data_q, data_d;
  logic [TW-1:0]       tag_q, tag_d;

  assign load_o = !valid_q || down_load_i;

  // NOTE: every variable gets its hold value first, so no path through this block can infer a latch.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    tag_d   = tag_q;
    if (load_o) begin
      valid_d = valid_i;
      if (valid_i) begin
        data_d = data_i;
        tag_d  = tag_i;
      end
    end
  end

  // NOTE: data and tag are reset too (not just valid) because out_sum/out_tag must read 0 during reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      tag_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      tag_q   <= tag_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign tag_o   = tag_q;

endmodule

// File: rtl/adder_tree_stream.sv
// Pipelined, back-pressured masked adder tree: sums LENGTH addends per vector
// with a tag carried alongside, one vector per cycle when unstalled.
module adder_tree_stream
  import adder_tree_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int LENGTH     = 16,
  parameter int SIGNED     = 0,
  parameter int STAGES     = tree_levels(LENGTH),
  parameter int TAG_WIDTH  = 4,
  localparam int OUT_WIDTH = sum_width(DATA_WIDTH, LENGTH)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_addends [LENGTH],
  input  logic [LENGTH-1:0]     in_mask,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_WIDTH-1:0]  out_sum,
  output logic [TAG_WIDTH-1:0]  out_tag
);

  localparam int LEVELS = tree_levels(LENGTH);

  typedef logic [LENGTH-1:0][OUT_WIDTH-1:0] vec_t;

  vec_t in_ext;

  // Extend to full sum width up front so every adder is exact; masked lanes become zero.
  always_comb begin
    in_ext = '0;
    for (int i = 0; i < LENGTH; i++) begin
      if (in_mask[i]) begin
        if (SIGNED != 0) in_ext[i] = OUT_WIDTH'($signed(in_addends[i]));
        else             in_ext[i] = OUT_WIDTH'(in_addends[i]);
      end
    end
  end

  for (genvar k = 1; k <= STAGES; k++) begin : g_stage
    localparam int LVL_LO = stage_level(k - 1, LEVELS, STAGES);
    localparam int LVL_HI = stage_level(k, LEVELS, STAGES);
    localparam int N_LO   = level_count(LENGTH, LVL_LO);
    localparam int N_HI   = level_count(LENGTH, LVL_HI);

    logic [N_LO-1:0][OUT_WIDTH-1:0] src_data;
    logic [N_HI-1:0][OUT_WIDTH-1:0] red_data, data_q;
    logic                           src_valid, down_load, load, valid_q;
    logic [TAG_WIDTH-1:0]           src_tag, tag_q;

    if (k == 1) begin : g_head
      assign src_data  = in_ext;
      assign src_valid = in_valid;
      assign src_tag   = in_tag;
    end else begin : g_body
      assign src_data  = g_stage[k-1].data_q;
      assign src_valid = g_stage[k-1].valid_q;
      assign src_tag   = g_stage[k-1].tag_q;
    end

    if (k == STAGES) begin : g_tail
      assign down_load = out_ready;
    end else begin : g_mid
      assign down_load = g_stage[k+1].load;
    end

    // Pairs (2j, 2j+1) fold into slot j; an odd last element lands alone and passes through.
    always_comb begin
      vec_t work, nxt;
      work = '0;
      nxt  = '0;
      work[N_LO-1:0] = src_data;
      for (int l = LVL_LO; l < LVL_HI; l++) begin
        nxt = '0;
        for (int i = 0; i < LENGTH; i++) nxt[i/2] = nxt[i/2] + work[i];
        work = nxt;
      end
      red_data = work[N_HI-1:0];
    end

    adder_tree_stage #(
      .N  (N_HI),
      .W  (OUT_WIDTH),
      .TW (TAG_WIDTH)
    ) u_stage (
      .clk         (clk),
      .reset_n     (reset_n),
      .valid_i     (src_valid),
      .data_i      (red_data),
      .tag_i       (src_tag),
      .down_load_i (down_load),
      .load_o      (load),
      .valid_o     (valid_q),
      .data_o      (data_q),
      .tag_o       (tag_q)
    );
  end

  // Held low while reset is asserted, even though the empty stage 1 would otherwise load.
  assign in_ready  = reset_n && g_stage[1].load;
  assign out_valid = g_stage[STAGES].valid_q;
  assign out_sum   = g_stage[STAGES].data_q[0];
  assign out_tag   = g_stage[STAGES].tag_q;

endmodule
